// File: rtl/mem_bank_prog_ctrl.sv
`default_nettype none
// ============================================================================
// mem_bank_prog_ctrl: streams bitstream words into one BL row, then strobes
// one-hot WL per row for a tiled memory-bank column chain.      Rev 1.0
// ============================================================================
module mem_bank_prog_ctrl #(
  parameter int NUM_BL   = 315,
  parameter int NUM_WL   = 4,
  parameter int DATA_W   = 8,
  parameter int WL_PULSE = 2,
  localparam int ROW_W   = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [NUM_BL-1:0] bl_out,
  output logic [NUM_WL-1:0] wl_out,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  row_idx
);

  localparam int CHUNKS  = (NUM_BL + DATA_W - 1) / DATA_W;
  localparam int CNT_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PULSE_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
  localparam logic [CNT_W-1:0]   LAST_WORD  = CNT_W'(CHUNKS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NUM_WL - 1);
  localparam logic [PULSE_W-1:0] LAST_PULSE = PULSE_W'(WL_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   word_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [31:0]        shamt;
  logic [NUM_BL-1:0]  slice_data;
  logic [NUM_BL-1:0]  slice_mask;
  logic [NUM_BL-1:0]  bl_next;

  // Shifting in NUM_BL width drops the bits of the last word past the row end.
  assign shamt      = 32'(word_cnt) * DATA_W;
  assign slice_data = NUM_BL'(din) << shamt;
  assign slice_mask = NUM_BL'({DATA_W{1'b1}}) << shamt;
  assign bl_next    = (bl_out & ~slice_mask) | slice_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      word_cnt  <= '0;
      pulse_cnt <= '0;
      bl_out    <= '0;
      wl_out    <= '0;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      row_idx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            din_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            row_idx   <= '0;
            word_cnt  <= '0;
          end
        end
        LOAD: begin
          if (din_valid && din_ready) begin
            bl_out <= bl_next;
            if (word_cnt == LAST_WORD) begin
              // Last slice and WL rise share an edge; BL is then frozen.
              state     <= WRITE;
              din_ready <= 1'b0;
              pulse_cnt <= '0;
              wl_out    <= NUM_WL'(1) << row_idx;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (pulse_cnt == LAST_PULSE) begin
            state  <= HOLD;
            wl_out <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (row_idx == LAST_ROW) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= LOAD;
            din_ready <= 1'b1;
            row_idx   <= row_idx + 1'b1;
            word_cnt  <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          wl_out    <= '0;
          din_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_prog_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_bank_prog_ctrl: directed bench with a row-level reference model.
// ============================================================================
`timescale 1ns/1ps
module tb_mem_bank_prog_ctrl;

  localparam int NUM_BL   = 315;
  localparam int NUM_WL   = 4;
  localparam int DATA_W   = 8;
  localparam int WL_PULSE = 2;
  localparam int ROW_W    = 2;
  localparam int CHUNKS   = (NUM_BL + DATA_W - 1) / DATA_W;
  localparam int RUN_CYC  = 1 + NUM_WL * (CHUNKS + WL_PULSE + 1);

  logic              clk = 1'b0;
  logic              reset, start, din_valid;
  logic [DATA_W-1:0] din;
  logic              din_ready, busy, done;
  logic [NUM_BL-1:0] bl_out;
  logic [NUM_WL-1:0] wl_out;
  logic [ROW_W-1:0]  row_idx;

  always #5 clk = ~clk;

  mem_bank_prog_ctrl #(
    .NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .DATA_W(DATA_W), .WL_PULSE(WL_PULSE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .bl_out(bl_out), .wl_out(wl_out), .busy(busy),
    .done(done), .row_idx(row_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [NUM_BL-1:0] act, input logic [NUM_BL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Row r carries global word indices r*CHUNKS .. r*CHUNKS+CHUNKS-1.
  function automatic logic [NUM_BL-1:0] exp_row(input int r);
    logic [NUM_BL-1:0] v;
    v = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      logic [DATA_W-1:0] w;
      w = DATA_W'(r * CHUNKS + k);
      for (int j = 0; j < DATA_W; j++)
        if (k * DATA_W + j < NUM_BL) v[k * DATA_W + j] = w[j];
    end
    return v;
  endfunction

  // Reference model: a run is "active" between start and the last HOLD.
  // Within a row, m_wcnt counts words taken; once all are in, m_post counts
  // cycles past the last transfer (WL for WL_PULSE of them, then one hold).
  logic [NUM_BL-1:0] m_bl = '0;
  int  m_row = 0, m_wcnt = 0, m_post = 0;
  bit  m_active = 0, m_busy = 0, m_done = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_bl = '0; m_row = 0; m_wcnt = 0; m_post = 0;
      m_active = 0; m_busy = 0; m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_busy = 1; m_done = 0;
        m_row = 0; m_wcnt = 0; m_post = 0;
      end
    end else if (m_wcnt < CHUNKS) begin
      if (din_valid) begin
        for (int j = 0; j < DATA_W; j++)
          if (m_wcnt * DATA_W + j < NUM_BL) m_bl[m_wcnt * DATA_W + j] = din[j];
        m_wcnt++;
      end
    end else begin
      m_post++;
      if (m_post == WL_PULSE + 1) begin
        if (m_row == NUM_WL - 1) begin
          m_active = 0; m_busy = 0; m_done = 1;
        end else begin
          m_row++; m_wcnt = 0; m_post = 0;
        end
      end
    end
  end

  bit                cmp_on = 0;
  bit                prev_rst = 1;
  logic [NUM_WL-1:0] prev_wl = '0;
  logic [NUM_BL-1:0] prev_bl = '0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("bl_out", bl_out, m_bl);
      chk("wl_out", wl_out,
          NUM_BL'((m_active && m_wcnt == CHUNKS && m_post < WL_PULSE) ? (1 << m_row) : 0));
      chk("din_ready", din_ready, NUM_BL'(m_active && m_wcnt < CHUNKS));
      chk("busy", busy, NUM_BL'(m_busy));
      chk("done", done, NUM_BL'(m_done));
      chk("row_idx", row_idx, NUM_BL'(m_row));
      chk("wl_onehot0", NUM_BL'($onehot0(wl_out)), 1);
      if (prev_wl != 0 && !prev_rst) chk("bl_stable_wl", bl_out, prev_bl);
    end
    prev_wl  = wl_out;
    prev_bl  = bl_out;
    prev_rst = reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word();
    din = DATA_W'(m_row * CHUNKS + m_wcnt);
  endtask

  // mode 0: valid always high, 1: toggling, 2: random. glitch: stray start in row 2.
  task automatic run(input int mode, input bit glitch, output int cyc, output logic [NUM_BL-1:0] snap0);
    int pulses [NUM_WL];
    foreach (pulses[r]) pulses[r] = 0;
    snap0 = '0;
    start = 1'b1; din_valid = 1'b1; drive_word();
    step();
    start = 1'b0; cyc = 1;
    chk("start_done_clr", done, 0);
    chk("start_busy", busy, 1);
    chk("start_row0", row_idx, 0);
    while (!done && cyc < 1000) begin
      for (int r = 0; r < NUM_WL; r++) begin
        if (wl_out == NUM_WL'(1 << r)) begin
          if (pulses[r] == 0) begin
            chk($sformatf("row%0d_bl", r), bl_out, exp_row(r));
            if (r == 0) snap0 = bl_out;
          end
          pulses[r]++;
        end
      end
      case (mode)
        0:       din_valid = 1'b1;
        1:       din_valid = cyc[0];
        default: din_valid = 1'($urandom_range(0, 1));
      endcase
      start = (glitch && m_row == 2 && m_wcnt == 5) ? 1'b1 : 1'b0;
      drive_word();
      step();
      cyc++;
    end
    start = 1'b0;
    chk("run_done_seen", done, 1);
    for (int r = 0; r < NUM_WL; r++) chk($sformatf("row%0d_pulse_len", r), pulses[r], WL_PULSE);
  endtask

  initial begin
    int cyc;
    int guard;
    logic [NUM_BL-1:0] snap0;
    reset = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
    step();
    cmp_on = 1;
    step();
    reset = 1'b0;
    chk("rst_bl", bl_out, 0);
    chk("rst_wl", wl_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_row", row_idx, 0);

    // Reset during the first WL cycle of row 1.
    start = 1'b1; din_valid = 1'b1; drive_word();
    step();
    start = 1'b0; guard = 0;
    while (wl_out != 4'b0010 && guard < 200) begin
      drive_word(); step(); guard++;
    end
    chk("reach_row1_wl", wl_out, 4'b0010);
    reset = 1'b1;
    step();
    reset = 1'b0; din_valid = 1'b0;
    chk("midrst_wl", wl_out, 0);
    chk("midrst_bl", bl_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", din_ready, 0);
    step();

    // Full run after the mid-operation reset.
    run(0, 0, cyc, snap0);
    chk("full_cycles", cyc, RUN_CYC);
    chk("full_cycles_lit", cyc, 173);
    chk("row0_lo_byte", snap0[7:0], 8'h00);
    chk("row0_hi_bits", snap0[314:312], 3'b111);

    // Extra words offered in DONE must not be taken.
    din_valid = 1'b1; din = 8'hA5;
    for (int i = 0; i < 5; i++) step();
    chk("done_row3", row_idx, 3);
    chk("done_ready", din_ready, 0);
    chk("done_bl_hold", bl_out, exp_row(3));
    chk("done_busy", busy, 0);

    // Restart from DONE with a stray start during row 2.
    run(0, 1, cyc, snap0);
    chk("restart_cycles", cyc, 173);

    run(1, 0, cyc, snap0);
    chk("toggle_row0_lo", snap0[7:0], 8'h00);
    run(2, 0, cyc, snap0);
    chk("random_row0_hi", snap0[314:312], 3'b111);

    din_valid = 1'b0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
